reg_dump_reader: RTL and testbench

- Debug/trace block that sits on a spare combinational read port of the integer register file and walks it sequentially.
- On a start pulse, it reads registers x0..x(NUM_REGS-1) one by one.
- Each value is presented on a valid/ready output stream with its index.
- It is the read-side counterpart to the core's writeback path and feeds the debug UART/trace buffer.

---
 rtl/reg_dump_reader.sv | 94 +++++++++
 tb/tb_reg_dump_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Walks the integer register file through a spare combinational read port.
// Each register value is emitted on a valid/ready stream together with its index.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SKIP_X0  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // idx only moves on start or after a non-final handshake, so in IDLE the
  // read address keeps the last index walked.
  assign rf_addr = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // Cancel overrides the hold-until-ready rule; captured data is kept.
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= FIRST_IDX;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          out_data  <= rf_data;
          out_index <= idx;
          out_last  <= (idx == LAST_IDX);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // Terminal compare precedes the increment, so idx never wraps.
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: unit 0 walks from x0, unit 1 skips x0.
// Expected words are queued at start from the bench register file; a negedge monitor checks them.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rf [32];

  logic [4:0]  ra    [2];
  logic [31:0] rdata [2];
  logic [31:0] od    [2];
  logic [4:0]  oidx  [2];
  logic        ov    [2];
  logic        ol    [2];
  logic        busy  [2];
  logic        done  [2];
  logic        start [2];
  logic        abort [2];
  logic        ready [2];

  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int busy_cnt [2];
  int done_cnt [2];
  int last_hs  [2];
  bit          held   [2];
  logic [31:0] held_d [2];
  logic [4:0]  held_i [2];

  always #5 clk = ~clk;

  assign rdata[0] = (ra[0] == 5'd0) ? 32'd0 : rf[ra[0]];
  assign rdata[1] = (ra[1] == 5'd0) ? 32'd0 : rf[ra[1]];

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .rf_addr(ra[0]), .rf_data(rdata[0]), .out_valid(ov[0]), .out_ready(ready[0]),
    .out_data(od[0]), .out_index(oidx[0]), .out_last(ol[0]), .busy(busy[0]), .done(done[0])
  );

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .rf_addr(ra[1]), .rf_data(rdata[1]), .out_valid(ov[1]), .out_ready(ready[1]),
    .out_data(od[1]), .out_index(oidx[1]), .out_last(ol[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_reg(input int i);
    return (i == 0) ? 32'd0 : rf[i];
  endfunction

  // Reference: a dump yields every register from the first index up to x31, last flag on x31.
  task automatic push_dump(input int u);
    exp_t e;
    for (int i = (u == 1) ? 1 : 0; i < 32; i++) begin
      e.d = model_reg(i);
      e.i = 5'(i);
      e.l = (i == 31);
      if (u == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        held[u] = 1'b0;
      end else begin
        if (busy[u]) busy_cnt[u]++;
        if (done[u]) begin
          done_cnt[u]++;
          check("done_after_last", 64'(cyc_n - last_hs[u]), 64'd1);
        end
        if (held[u]) begin
          check("hold_valid", 64'(ov[u]), 64'd1);
          check("hold_data", 64'(od[u]), 64'(held_d[u]));
          check("hold_index", 64'(oidx[u]), 64'(held_i[u]));
        end
        held[u]   = ov[u] && !ready[u] && !abort[u];
        held_d[u] = od[u];
        held_i[u] = oidx[u];
        if (ov[u] && ready[u] && !abort[u]) begin
          if (qsize(u) == 0) begin
            check("unexpected_word", 64'(oidx[u]), 64'hFFFF);
          end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            check("word_data", 64'(od[u]), 64'(e.d));
            check("word_index", 64'(oidx[u]), 64'(e.i));
            check("word_last", 64'(ol[u]), 64'(e.l));
            if (e.l) last_hs[u] = cyc_n;
          end
        end
      end
    end
  end

  task automatic drive_dump(input int u, input int stall_idx, input int stall_len,
                            input bit do_write, input logic [31:0] wdata,
                            input int abort_idx, input int mid_start, input bit rnd_ready);
    int cyc = 0;
    int stalled = 0;
    int rise = -1;
    int nwords;
    bit aborted = 1'b0;
    bit seen_next = 1'b0;
    nwords = (u == 1) ? 31 : 32;
    push_dump(u);
    busy_cnt[u] = 0;
    done_cnt[u] = 0;
    ready[u] = 1'b1;
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    check("fetch_not_valid", 64'(ov[u]), 64'd0);
    check("fetch_busy", 64'(busy[u]), 64'd1);
    while (busy[u] && cyc < 1000) begin
      start[u] = (cyc == mid_start);
      if (cyc == 1) check("first_word_latency", 64'(ov[u]), 64'd1);
      if (abort_idx >= 0 && ov[u] && int'(oidx[u]) == abort_idx) begin
        abort[u] = 1'b1;
        ready[u] = 1'b1;
        tick();
        abort[u] = 1'b0;
        aborted = 1'b1;
        check("abort_valid", 64'(ov[u]), 64'd0);
        check("abort_busy", 64'(busy[u]), 64'd0);
        check("abort_index_kept", 64'(oidx[u]), 64'(abort_idx));
        if (u == 0) q0.delete(); else q1.delete();
        break;
      end
      if (ov[u] && int'(oidx[u]) == stall_idx && stalled < stall_len) begin
        ready[u] = 1'b0;
        stalled++;
        if (do_write && stalled == 2) rf[stall_idx] = wdata;
      end else begin
        if (stall_len > 0 && stalled == stall_len && rise < 0) rise = cyc;
        ready[u] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rise >= 0 && !seen_next && ov[u] && int'(oidx[u]) == stall_idx + 1) begin
        seen_next = 1'b1;
        check("resume_latency", 64'(cyc - rise), 64'd2);
      end
      tick();
      cyc++;
    end
    start[u] = 1'b0;
    ready[u] = 1'b1;
    check("dump_in_budget", 64'(cyc < 1000), 64'd1);
    repeat (3) tick();
    check("done_count", 64'(done_cnt[u]), aborted ? 64'd0 : 64'd1);
    if (!aborted) check("queue_drained", 64'(qsize(u)), 64'd0);
    if (!aborted && !rnd_ready && stall_len == 0)
      check("busy_cycles", 64'(busy_cnt[u]), 64'(2 * nwords + 1));
  endtask

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; abort[u] = 1'b0; ready[u] = 1'b1;
      busy_cnt[u] = 0; done_cnt[u] = 0; last_hs[u] = -10; held[u] = 1'b0;
    end
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[0] = 32'd0;

    #1;
    for (int u = 0; u < 2; u++)
      check("reset_outputs", {ra[u], od[u], oidx[u], ov[u], ol[u], busy[u], done[u]}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    drive_dump(0, -1, 0, 1'b0, 32'd0, -1, -1, 1'b0);
    drive_dump(0, 3, 5, 1'b0, 32'd0, -1, -1, 1'b0);
    drive_dump(0, 7, 3, 1'b1, 32'hDEAD_BEEF, -1, -1, 1'b0);
    drive_dump(0, -1, 0, 1'b0, 32'd0, -1, -1, 1'b0);

    drive_dump(0, -1, 0, 1'b0, 32'd0, 10, -1, 1'b0);
    start[0] = 1'b1; abort[0] = 1'b1;
    tick();
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort_idle", 64'(busy[0]), 64'd0);
    drive_dump(0, -1, 0, 1'b0, 32'd0, -1, -1, 1'b0);

    drive_dump(1, -1, 0, 1'b0, 32'd0, -1, 20, 1'b0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      drive_dump(k % 2, -1, 0, 1'b0, 32'd0, -1, -1, 1'b1);
    end

    // Reset dropped mid-FETCH of x2, between clock edges.
    push_dump(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (!(busy[0] && !ov[0] && oidx[0] == 5'd1) && n < 50) begin
      tick();
      n++;
    end
    check("reached_fetch", 64'(n < 50), 64'd1);
    check("fetch_addr", 64'(ra[0]), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {ra[0], od[0], oidx[0], ov[0], ol[0], busy[0], done[0]}, 64'd0);
    q0.delete();
    tick();
    rst_n = 1'b1;
    done_cnt[0] = 0;
    repeat (3) tick();
    check("idle_after_reset", {busy[0], ov[0], done[0]}, 64'd0);
    check("no_done_after_reset", 64'(done_cnt[0]), 64'd0);
    drive_dump(0, -1, 0, 1'b0, 32'd0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
